// File: rtl/video_bar_ctrl.sv
// Bar pattern controller: bus register file, frame-synchronous config load,
// auto pattern rotation, generator vertical steering and output pixel mux.
module video_bar_ctrl #(
    parameter int FRAME_HOLD = 60,
    parameter int H_SIZE     = 10,
    parameter int V_SIZE     = 10,
    parameter int H_DISPLAY  = 640,
    parameter int V_DISPLAY  = 480
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [H_SIZE-1:0] hc,
    input  logic [V_SIZE-1:0] vc,
    input  logic [11:0]       src_rgb,
    output logic [H_SIZE-1:0] gen_hc,
    output logic [V_SIZE-1:0] gen_vc,
    input  logic [11:0]       bar_rgb,
    output logic [11:0]       rgb_out,
    input  logic              cs,
    input  logic              write,
    input  logic [1:0]        addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata
);

    // Bit layout matches the CTRL register: [3:2] mode, [1] auto, [0] enable.
    typedef struct packed {
        logic [1:0] mode;
        logic       auto_rot;
        logic       en;
    } ctrl_t;

    localparam ctrl_t             CTRL_RST = '{mode: 2'd0, auto_rot: 1'b0, en: 1'b1};
    localparam logic [7:0]        HOLD_RST = 8'(FRAME_HOLD);
    localparam logic [H_SIZE-1:0] H_DISP   = H_SIZE'(H_DISPLAY);
    localparam logic [V_SIZE-1:0] V_DISP   = V_SIZE'(V_DISPLAY);
    localparam logic [V_SIZE-1:0] VC_BAND1 = V_SIZE'(V_DISPLAY / 3);
    localparam logic [V_SIZE-1:0] VC_BAND2 = V_SIZE'((V_DISPLAY / 3) * 2);

    ctrl_t       pend_ctrl_q, pend_ctrl_d;
    ctrl_t       act_ctrl_q,  act_ctrl_d;
    ctrl_t       eff_ctrl;
    logic [7:0]  pend_hold_q, pend_hold_d;
    logic [7:0]  act_hold_q,  act_hold_d;
    logic [7:0]  hold_cnt_q,  hold_cnt_d;
    logic [7:0]  hold_max;
    logic        dirty_q,     dirty_d;
    logic [11:0] rgb_out_q,   rgb_out_d;
    logic [31:0] rdata_q,     rdata_d;
    logic        frame_start;
    logic        bus_wr;
    logic        bus_rd;
    logic        unused_wdata;

    assign frame_start  = (hc == '0) && (vc == '0);
    assign bus_wr       = cs && write;
    assign bus_rd       = cs && !write;
    assign hold_max     = (act_hold_q == 8'd0) ? 8'd0 : act_hold_q - 8'd1;
    assign unused_wdata = ^wdata[31:8];

    always_comb begin
        // NOTE: every variable gets its hold value first so no path can infer a latch.
        pend_ctrl_d = pend_ctrl_q;
        pend_hold_d = pend_hold_q;
        act_ctrl_d  = act_ctrl_q;
        act_hold_d  = act_hold_q;
        hold_cnt_d  = hold_cnt_q;
        dirty_d     = dirty_q;

        if (frame_start) begin
            if (dirty_q) begin
                act_ctrl_d = pend_ctrl_q;
                act_hold_d = pend_hold_q;
                hold_cnt_d = 8'd0;
                dirty_d    = 1'b0;
            end else if (act_ctrl_q.auto_rot) begin
                if (hold_cnt_q == hold_max) begin
                    act_ctrl_d.mode  = act_ctrl_q.mode + 2'd1;
                    pend_ctrl_d.mode = act_ctrl_q.mode + 2'd1;
                    hold_cnt_d       = 8'd0;
                end else begin
                    hold_cnt_d = hold_cnt_q + 8'd1;
                end
            end
        end

        // A bus write lands after the frame logic so it always wins in pending.
        if (bus_wr) begin
            case (addr)
                2'd0: begin
                    pend_ctrl_d = ctrl_t'(wdata[3:0]);
                    dirty_d     = 1'b1;
                end
                2'd1: begin
                    pend_hold_d = wdata[7:0];
                    dirty_d     = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        // The frame_start pixel already sees the settings loaded on this edge.
        eff_ctrl = frame_start ? act_ctrl_d : act_ctrl_q;

        case (eff_ctrl.mode)
            2'd0:    gen_vc = vc;
            2'd1:    gen_vc = '0;
            2'd2:    gen_vc = VC_BAND1;
            default: gen_vc = VC_BAND2;
        endcase

        if (hc >= H_DISP || vc >= V_DISP) begin
            rgb_out_d = 12'h000;
        end else if (eff_ctrl.en) begin
            rgb_out_d = bar_rgb;
        end else begin
            rgb_out_d = src_rgb;
        end

        rdata_d = rdata_q;
        if (bus_rd) begin
            case (addr)
                2'd0:    rdata_d = {28'd0, pend_ctrl_q};
                2'd1:    rdata_d = {24'd0, pend_hold_q};
                2'd2:    rdata_d = {16'd0, hold_cnt_q, 4'd0, act_ctrl_q.auto_rot,
                                    act_ctrl_q.en, act_ctrl_q.mode};
                default: rdata_d = 32'd0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pend_ctrl_q <= CTRL_RST;
            act_ctrl_q  <= CTRL_RST;
            pend_hold_q <= HOLD_RST;
            act_hold_q  <= HOLD_RST;
            hold_cnt_q  <= 8'd0;
            dirty_q     <= 1'b0;
            rgb_out_q   <= 12'h000;
            rdata_q     <= 32'd0;
        end else begin
            // NOTE: non-blocking updates so every flop samples pre-edge values.
            pend_ctrl_q <= pend_ctrl_d;
            act_ctrl_q  <= act_ctrl_d;
            pend_hold_q <= pend_hold_d;
            act_hold_q  <= act_hold_d;
            hold_cnt_q  <= hold_cnt_d;
            dirty_q     <= dirty_d;
            rgb_out_q   <= rgb_out_d;
            rdata_q     <= rdata_d;
        end
    end

    assign gen_hc  = hc;
    assign rgb_out = rgb_out_q;
    assign rdata   = rdata_q;

endmodule

// File: tb/tb_video_bar_ctrl.sv
// Directed bench for video_bar_ctrl: vector table of bus ops and pixels,
// plus hand sequences for frame_start-coincident writes, HOLD=0 and reset.
module tb_video_bar_ctrl;

    typedef enum logic [1:0] {OP_PIX, OP_WR, OP_RD} op_e;

    typedef struct {
        op_e         op;
        logic [9:0]  hc;
        logic [9:0]  vc;
        logic [11:0] src;
        logic [1:0]  addr;
        logic [31:0] data;
        logic [9:0]  gvc;
        logic [11:0] rgb;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [9:0]  hc_i = 10'd5;
    logic [9:0]  vc_i = 10'd5;
    logic [11:0] src_rgb = 12'h000;
    logic [9:0]  gen_hc;
    logic [9:0]  gen_vc;
    logic [11:0] bar_rgb;
    logic [11:0] rgb_out;
    logic        cs = 1'b0;
    logic        wr_i = 1'b0;
    logic [1:0]  addr = 2'd0;
    logic [31:0] wdata = 32'd0;
    logic [31:0] rdata;

    int errors = 0;
    int checks = 0;
    vec_t vecs[$];

    video_bar_ctrl dut (
        .clk(clk), .rst(rst), .hc(hc_i), .vc(vc_i), .src_rgb(src_rgb),
        .gen_hc(gen_hc), .gen_vc(gen_vc), .bar_rgb(bar_rgb), .rgb_out(rgb_out),
        .cs(cs), .write(wr_i), .addr(addr), .wdata(wdata), .rdata(rdata)
    );

    always #5 clk = ~clk;

    // Generator stand-in: gray ramp, primary and rainbow bands by line.
    function automatic logic [11:0] gm(input logic [9:0] h, input logic [9:0] v);
        if (v < 10'd160)      return {h[9:6], h[9:6], h[9:6]};
        else if (v < 10'd320) return {h[7:4], 8'h00};
        else                  return {4'h0, h[7:4], 4'hF};
    endfunction

    assign bar_rgb = gm(gen_hc, gen_vc);

    function automatic vec_t pix(input logic [9:0] h, input logic [9:0] v,
                                 input logic [11:0] s, input logic [9:0] g,
                                 input logic [11:0] r);
        vec_t t = '{op: OP_PIX, hc: h, vc: v, src: s, addr: 2'd0, data: 32'd0,
                    gvc: g, rgb: r};
        return t;
    endfunction

    function automatic vec_t wr(input logic [1:0] a, input logic [31:0] d);
        vec_t t = '{op: OP_WR, hc: 10'd5, vc: 10'd5, src: 12'h0, addr: a, data: d,
                    gvc: 10'd0, rgb: 12'h0};
        return t;
    endfunction

    function automatic vec_t rd(input logic [1:0] a, input logic [31:0] d);
        vec_t t = '{op: OP_RD, hc: 10'd5, vc: 10'd5, src: 12'h0, addr: a, data: d,
                    gvc: 10'd0, rgb: 12'h0};
        return t;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic do_pix(input logic [9:0] h, input logic [9:0] v, input logic [11:0] s,
                          input logic [9:0] g, input logic [11:0] r, input string tag);
        hc_i = h; vc_i = v; src_rgb = s; cs = 1'b0;
        #1;
        check({tag, " gen_vc"}, 32'(gen_vc), 32'(g));
        @(posedge clk); #1;
        check({tag, " rgb_out"}, 32'(rgb_out), 32'(r));
    endtask

    task automatic do_wr(input logic [1:0] a, input logic [31:0] d);
        hc_i = 10'd5; vc_i = 10'd5; cs = 1'b1; wr_i = 1'b1; addr = a; wdata = d;
        @(posedge clk); #1;
        cs = 1'b0; wr_i = 1'b0;
    endtask

    task automatic do_rd(input logic [1:0] a, input logic [31:0] exp, input string tag);
        hc_i = 10'd5; vc_i = 10'd5; cs = 1'b1; wr_i = 1'b0; addr = a;
        @(posedge clk); #1;
        cs = 1'b0;
        check({tag, " rdata"}, rdata, exp);
    endtask

    initial begin
        // Reset state and defaults, default mode 0 enabled.
        vecs.push_back(rd(2'd0, 32'h1));
        vecs.push_back(rd(2'd1, 32'd60));
        vecs.push_back(rd(2'd2, 32'h4));
        vecs.push_back(pix(10'd0,   10'd0,   12'hABC, 10'd0,   12'h000));
        vecs.push_back(pix(10'd100, 10'd10,  12'hABC, 10'd10,  12'h111));
        vecs.push_back(pix(10'd600, 10'd200, 12'hABC, 10'd200, 12'h500));
        vecs.push_back(pix(10'd100, 10'd400, 12'hABC, 10'd400, 12'h06F));
        vecs.push_back(pix(10'd700, 10'd10,  12'hABC, 10'd10,  12'h000));
        vecs.push_back(pix(10'd10,  10'd490, 12'hABC, 10'd490, 12'h000));
        // Mode 2 write: nothing changes until the frame boundary.
        vecs.push_back(wr(2'd0, 32'h9));
        vecs.push_back(rd(2'd0, 32'h9));
        vecs.push_back(rd(2'd2, 32'h4));
        vecs.push_back(pix(10'd100, 10'd400, 12'hABC, 10'd400, 12'h06F));
        vecs.push_back(pix(10'd0,   10'd0,   12'hABC, 10'd160, 12'h000));
        vecs.push_back(pix(10'd100, 10'd10,  12'hABC, 10'd160, 12'h600));
        vecs.push_back(pix(10'd200, 10'd400, 12'hABC, 10'd160, 12'hC00));
        vecs.push_back(rd(2'd2, 32'h6));
        // Disable: pass-through from the next frame.
        vecs.push_back(wr(2'd0, 32'h0));
        vecs.push_back(pix(10'd100, 10'd10,  12'h123, 10'd160, 12'h600));
        vecs.push_back(pix(10'd0,   10'd0,   12'h456, 10'd0,   12'h456));
        vecs.push_back(pix(10'd100, 10'd10,  12'h789, 10'd10,  12'h789));
        vecs.push_back(pix(10'd650, 10'd10,  12'hFFF, 10'd10,  12'h000));
        vecs.push_back(rd(2'd0, 32'h0));
        // Auto rotation with HOLD=2: modes 0,0,1,1,2,2,3,3,0.
        vecs.push_back(wr(2'd1, 32'h2));
        vecs.push_back(wr(2'd0, 32'h3));
        vecs.push_back(rd(2'd1, 32'h2));
        vecs.push_back(rd(2'd0, 32'h3));
        vecs.push_back(pix(10'd0,   10'd0,   12'hABC, 10'd0,   12'h000));
        vecs.push_back(pix(10'd100, 10'd10,  12'hABC, 10'd10,  12'h111));
        vecs.push_back(rd(2'd2, 32'h0C));
        vecs.push_back(pix(10'd0,   10'd0,   12'hABC, 10'd0,   12'h000));
        vecs.push_back(rd(2'd2, 32'h10C));
        vecs.push_back(pix(10'd0,   10'd0,   12'hABC, 10'd0,   12'h000));
        vecs.push_back(pix(10'd100, 10'd50,  12'hABC, 10'd0,   12'h111));
        vecs.push_back(rd(2'd0, 32'h7));
        vecs.push_back(rd(2'd2, 32'h0D));
        vecs.push_back(pix(10'd0,   10'd0,   12'hABC, 10'd0,   12'h000));
        vecs.push_back(rd(2'd2, 32'h10D));
        vecs.push_back(pix(10'd0,   10'd0,   12'hABC, 10'd160, 12'h000));
        vecs.push_back(pix(10'd100, 10'd50,  12'hABC, 10'd160, 12'h600));
        vecs.push_back(rd(2'd0, 32'hB));
        vecs.push_back(pix(10'd0,   10'd0,   12'hABC, 10'd160, 12'h000));
        vecs.push_back(pix(10'd0,   10'd0,   12'hABC, 10'd320, 12'h00F));
        vecs.push_back(pix(10'd100, 10'd50,  12'hABC, 10'd320, 12'h06F));
        vecs.push_back(rd(2'd0, 32'hF));
        vecs.push_back(rd(2'd2, 32'h0F));
        vecs.push_back(pix(10'd0,   10'd0,   12'hABC, 10'd320, 12'h00F));
        vecs.push_back(pix(10'd0,   10'd0,   12'hABC, 10'd0,   12'h000));
        vecs.push_back(pix(10'd100, 10'd50,  12'hABC, 10'd50,  12'h111));
        vecs.push_back(rd(2'd0, 32'h3));

        #2;
        check("reset rgb_out", 32'(rgb_out), 32'h0);
        check("reset rdata", rdata, 32'h0);
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;

        foreach (vecs[i]) begin
            string tag;
            tag = $sformatf("vec%0d", i);
            case (vecs[i].op)
                OP_PIX:  do_pix(vecs[i].hc, vecs[i].vc, vecs[i].src, vecs[i].gvc,
                                vecs[i].rgb, tag);
                OP_WR:   do_wr(vecs[i].addr, vecs[i].data);
                default: do_rd(vecs[i].addr, vecs[i].data, tag);
            endcase
        end

        // Write on the frame_start cycle itself: the auto count still steps,
        // and the new CTRL only loads at the following boundary.
        hc_i = 10'd0; vc_i = 10'd0; cs = 1'b1; wr_i = 1'b1; addr = 2'd0; wdata = 32'hD;
        #1;
        check("fs_wr gen_vc", 32'(gen_vc), 32'd0);
        @(posedge clk); #1;
        cs = 1'b0; wr_i = 1'b0;
        do_pix(10'd100, 10'd50, 12'hABC, 10'd50, 12'h111, "fs_wr same");
        do_rd(2'd2, 32'h10C, "fs_wr status");
        do_rd(2'd0, 32'hD, "fs_wr ctrl");
        do_pix(10'd0, 10'd0, 12'hABC, 10'd320, 12'h00F, "fs_wr load");
        do_pix(10'd100, 10'd50, 12'hABC, 10'd320, 12'h06F, "fs_wr after");
        do_rd(2'd2, 32'h07, "fs_wr status2");

        // STATUS and reserved writes ignored; reserved reads 0; rdata holds.
        do_wr(2'd2, 32'hFFFF_FFFF);
        do_rd(2'd2, 32'h07, "ro status");
        do_wr(2'd3, 32'hFFFF_FFFF);
        do_rd(2'd3, 32'h0, "rsvd");
        do_rd(2'd0, 32'hD, "ctrl after rsvd");
        repeat (3) @(posedge clk);
        #1;
        check("rdata hold", rdata, 32'hD);

        // HOLD=0 behaves as 1: advance on every frame.
        do_wr(2'd1, 32'h0);
        do_wr(2'd0, 32'h3);
        do_pix(10'd0, 10'd0, 12'hABC, 10'd0, 12'h000, "hold0 load");
        do_pix(10'd0, 10'd0, 12'hABC, 10'd0, 12'h000, "hold0 f1");
        do_rd(2'd2, 32'h0D, "hold0 status1");
        do_pix(10'd0, 10'd0, 12'hABC, 10'd160, 12'h000, "hold0 f2");
        do_rd(2'd2, 32'h0E, "hold0 status2");
        do_pix(10'd100, 10'd50, 12'hABC, 10'd160, 12'h600, "hold0 pix");
        do_rd(2'd0, 32'hB, "hold0 ctrl");

        // Mid-frame reset clears outputs at once and restores defaults.
        hc_i = 10'd100; vc_i = 10'd50;
        #2;
        rst = 1'b0;
        #1;
        check("midrst rgb_out", 32'(rgb_out), 32'h0);
        check("midrst rdata", rdata, 32'h0);
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        do_rd(2'd0, 32'h1, "midrst ctrl");
        do_rd(2'd1, 32'd60, "midrst hold");
        do_rd(2'd2, 32'h4, "midrst status");
        do_pix(10'd0, 10'd0, 12'hABC, 10'd0, 12'h000, "midrst fs");
        do_pix(10'd100, 10'd10, 12'hABC, 10'd10, 12'h111, "midrst pix");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/video_bar_ctrl.md
# video_bar_ctrl

Controller and configurator for the bar pattern generator in the video core. It owns a small register file on the core's simple bus and steers the generator's vertical coordinate so one band or the full three-band pattern fills the screen. It can auto-rotate patterns every N frames and muxes the generator output against the upstream pixel stream. All configuration changes take effect only at frame boundaries, so a frame never shows a mid-frame change.

## Interface
Parameters:
- FRAME_HOLD, default 60: reset value of the HOLD register, in frames per pattern in auto mode; range 1..255.
- Display geometry, `H_SIZE`, `V_SIZE`, `H_DISPLAY`, `V_DISPLAY`: from `vga.svh`.

Ports:
- clk  in  1  system/pixel clock; all logic is on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- hc  in  `H_SIZE`  current horizontal pixel counter.
- vc  in  `V_SIZE`  current vertical pixel counter.
- src_rgb  in  12  upstream pixel, passed through when the pattern is disabled.
- gen_hc  out  `H_SIZE`  to generator; equal to hc (combinational).
- gen_vc  out  `V_SIZE`  to generator; band-steered vertical coordinate (combinational).
- bar_rgb  in  12  generator output, combinational from gen_hc/gen_vc.
- rgb_out  out  12  registered output pixel.
- cs  in  1  bus select.
- write  in  1  1 = write, 0 = read; sampled when cs=1.
- addr  in  2  register address.
- wdata  in  32  write data.
- rdata  out  32  registered read data.

## Operation
- Registers:
  - 0 CTRL (rw): [0] enable, [1] auto, [3:2] mode. Mode 0 = three bands, 1 = gray, 2 = primary, 3 = rainbow.
  - 1 HOLD (rw): [7:0] frames per pattern. A value of 0 is treated as 1.
  - 2 STATUS (ro): [1:0] active mode, [2] active enable, [3] active auto, [15:8] hold counter.
  - 3: reserved; reads 0, writes ignored.
  - All unused bits read 0. Writes to STATUS are ignored.
- Writes go to pending CTRL/HOLD. Reads of CTRL/HOLD return the pending values.
- frame_start strobe = (hc==0 && vc==0). On that cycle the active registers load from the pending registers.
- Effect of a CTRL or HOLD write on the frame boundary:
  - A write marks pending dirty.
  - At the next frame_start, active is loaded, the hold counter clears, dirty clears, and no auto advance happens on that frame.
- Auto rotation (active auto=1, not dirty), at each frame_start:
  - If counter == max(HOLD,1)-1, mode advances 0→1→2→3→0 and the counter clears.
  - Otherwise the counter increments.
  - The advanced mode is also written back to pending mode, so CTRL reads track it.
- gen_vc by active mode: 0 → vc; 1 → 0; 2 → `V_DISPLAY`/3; 3 → (`V_DISPLAY`/3)*2.
- Pixel mux, priority order:
  - Outside the display area (hc ≥ `H_DISPLAY` or vc ≥ `V_DISPLAY`): 12'h000.
  - Enable=1: bar_rgb.
  - Otherwise: src_rgb.
- Reset values:
  - rgb_out=0, rdata=0.
  - pending and active CTRL = enable 1, auto 0, mode 0.
  - HOLD = FRAME_HOLD.
  - Counter 0, dirty 0.

## Timing
- Pixel latency: exactly 1 clk from hc/vc/src_rgb to rgb_out. The frame_start pixel already uses the newly loaded active settings; the load is combinationally bypassed for that cycle only.
- Bus: single-cycle, no wait states.
  - Write commits on the edge where cs=1 and write=1.
  - Read: rdata is valid on the clk following cs=1, write=0, and holds until the next read.
- Write on the same cycle as frame_start: the pending value is updated but NOT loaded this frame; it loads at the following frame_start.
- Auto advance and a pending write never coincide; the dirty path has priority.
- Reset asserted mid-frame: all state returns to reset values immediately. The first frame_start after release loads the defaults.

## Test plan
- Reset → rgb_out=0, CTRL reads 0x1, HOLD reads 60. At the first visible pixel (hc=0, vc=0), rgb_out one clk later equals the generator's gray value 12'h000.
- Write CTRL=0x9 (enable, mode 2) mid-frame → gen_vc stays vc until frame_start, then holds 160 (for 480 lines) for the whole next frame. STATUS[1:0]=2 after that boundary.
- Write CTRL=0x0 → from the next frame, rgb_out equals src_rgb delayed 1 clk inside the display area and 0 in blanking.
- HOLD=2, CTRL=0x3 (auto, enable, mode 0) → active mode sequence 0,0,1,1,2,2,3,3,0 across successive frames. CTRL reads track the mode.
- Write CTRL on the exact frame_start cycle → no change that frame; the change applies at the next frame_start.
- Read addr 3 → rdata=0 one clk later. Write STATUS → no change. Assert rst mid-frame → outputs 0 and registers return to their defaults.
